// File: rtl/adpll_pkg.sv
// -----------------------------------------------------------------------------
// adpll_pkg
// Shared definitions for the ADPLL loop blocks (phase detector, PI filter,
// DCO).
//   ERR_W      : width of the sign-magnitude error magnitude
//   SIGN_POS   : ref leads fb, the DCO must speed up
//   SIGN_NEG   : fb leads ref, the DCO must slow down
//   pd_state_t : phase detector measurement FSM states
// -----------------------------------------------------------------------------
package adpll_pkg;

  localparam int ERR_W = 5;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pd_state_t;

endpackage

// File: rtl/phase_detector_5bit_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous clock-like input into the clk domain through a
// SYNC_STAGES-deep flop chain, keeps one history flop behind the chain and
// produces a single-cycle pulse on every synchronised rising edge.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset (chain and history clear to 0)
//   din     : asynchronous input
//   rise    : one-cycle rising-edge pulse, clk domain
// -----------------------------------------------------------------------------
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Everything resets to 0, so an input held high through reset shows up as
  // exactly one edge once reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/phase_detector_5bit.sv
// -----------------------------------------------------------------------------
// phase_detector_5bit
// Counter-based phase/frequency detector for the ADPLL front end. Measures
// the distance in clk cycles between synchronised rising edges of ref_in and
// fb_in and emits one sign-magnitude error impulse per edge pair. Outside the
// impulse cycle the error outputs are held at zero so the downstream PI
// filter integrates exactly once per measurement.
// Ports:
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   enable      : synchronous measurement enable
//   ref_in      : reference clock (asynchronous)
//   fb_in       : DCO feedback clock (asynchronous)
//   error       : error magnitude, nonzero only with error_valid
//   error_sign  : 0 = ref leads fb, 1 = fb leads ref
//   error_valid : one-cycle strobe per completed measurement
//   busy        : high while a measurement window is open
// -----------------------------------------------------------------------------
module phase_detector_5bit
  import adpll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic [ERR_W-1:0] error,
  output logic             error_sign,
  output logic             error_valid,
  output logic             busy
);

  localparam logic [ERR_W-1:0] MAX_CNT = ERR_W'(MAX_COUNT);
  localparam logic [ERR_W-1:0] ONE_CNT = ERR_W'(1);

  // Counter step that sticks at MAX_CNT instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v >= MAX_CNT) begin
      return MAX_CNT;
    end
    return v + ONE_CNT;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: synchronised edge pulses
  // ---------------------------------------------------------------------------
  logic ref_edge_p0;
  logic fb_edge_p0;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ref_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ref_in),
    .rise    (ref_edge_p0)
  );

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (fb_in),
    .rise    (fb_edge_p0)
  );

  pd_state_t        state_q;
  pd_state_t        state_d;
  logic [ERR_W-1:0] cnt_q;
  logic [ERR_W-1:0] cnt_d;

  logic             vld_p0;
  logic [ERR_W-1:0] mag_p0;
  logic             sign_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The emission decided here is registered below, so error_valid appears
  // one cycle after the deciding edge pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_p0  = 1'b0;
    mag_p0  = '0;
    sign_p0 = SIGN_POS;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ref_edge_p0 && fb_edge_p0) begin
            // Coincident edges: zero phase error, no window opened.
            vld_p0  = 1'b1;
            mag_p0  = '0;
            sign_p0 = SIGN_POS;
          end else if (ref_edge_p0) begin
            state_d = REF_LEAD;
            cnt_d   = ONE_CNT;
          end else if (fb_edge_p0) begin
            state_d = FB_LEAD;
            cnt_d   = ONE_CNT;
          end
        end

        REF_LEAD: begin
          if (fb_edge_p0) begin
            // Window closes; a coincident new ref edge is dropped.
            vld_p0  = 1'b1;
            mag_p0  = cnt_q;
            sign_p0 = SIGN_POS;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (ref_edge_p0) begin
            // Cycle slip: ref edged twice without fb, report full scale and
            // restart the window from this new ref edge.
            vld_p0  = 1'b1;
            mag_p0  = MAX_CNT;
            sign_p0 = SIGN_POS;
            cnt_d   = ONE_CNT;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end

        FB_LEAD: begin
          if (ref_edge_p0) begin
            vld_p0  = 1'b1;
            mag_p0  = cnt_q;
            sign_p0 = SIGN_NEG;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (fb_edge_p0) begin
            vld_p0  = 1'b1;
            mag_p0  = MAX_CNT;
            sign_p0 = SIGN_NEG;
            cnt_d   = ONE_CNT;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: output register
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] err_p1;
  logic             sign_p1;
  logic             vld_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_p1  <= '0;
      sign_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (!enable) begin
      err_p1  <= '0;
      sign_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      err_p1  <= vld_p0 ? mag_p0  : '0;
      sign_p1 <= vld_p0 ? sign_p0 : 1'b0;
      vld_p1  <= vld_p0;
    end
  end

  assign error       = err_p1;
  assign error_sign  = sign_p1;
  assign error_valid = vld_p1;
  assign busy        = (state_q == REF_LEAD) || (state_q == FB_LEAD);

endmodule

// File: tb/tb_phase_detector_5bit.sv
module tb_phase_detector_5bit;

  localparam int S    = 2;
  localparam int MAXC = 31;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       ref_in;
  logic       fb_in;
  logic [4:0] error;
  logic       error_sign;
  logic       error_valid;
  logic       busy;

  phase_detector_5bit #(
    .SYNC_STAGES(S),
    .MAX_COUNT  (MAXC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .ref_in      (ref_in),
    .fb_in       (fb_in),
    .error       (error),
    .error_sign  (error_sign),
    .error_valid (error_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index: value N after the N-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int mag;
    int sign;
  } exp_t;

  exp_t sb[$];

  // An input raised at a falling edge is first sampled at edge N, its pulse
  // is seen by the FSM at edge N+S, so a lagging input sampled at N_lag
  // produces error_valid right after edge N_lag+S.
  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      check("missed_valid", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (error_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("error", int'(error), e.mag);
        check("error_sign", int'(error_sign), e.sign);
      end
    end else begin
      check("idle_error", int'(error), 0);
      check("idle_sign", int'(error_sign), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one edge pair: leader now, lagger gap cycles later (gap 0 = both).
  task automatic pair(input bit ref_lead, input int gap);
    int n_lead;
    exp_t e;
    n_lead = cyc + 1;
    if (gap == 0) begin
      ref_in = 1'b1;
      fb_in  = 1'b1;
    end else begin
      if (ref_lead) ref_in = 1'b1;
      else          fb_in  = 1'b1;
      step(gap);
      if (ref_lead) fb_in  = 1'b1;
      else          ref_in = 1'b1;
    end
    e.cyc  = n_lead + gap + S;
    e.mag  = sat(gap);
    e.sign = (gap == 0 || ref_lead) ? 0 : 1;
    sb.push_back(e);
    step(3);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(S + 3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got 0, expected 1 (run did not complete)");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    exp_t e;
    reset_n = 1'b0;
    enable  = 1'b1;
    ref_in  = 1'b0;
    fb_in   = 1'b0;
    step(3);
    check("rst_error", int'(error), 0);
    check("rst_sign", int'(error_sign), 0);
    check("rst_valid", int'(error_valid), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    step(3);
    check("post_rst_busy", int'(busy), 0);

    // busy latency after a lone ref pulse, then close the window
    c = cyc;
    ref_in = 1'b1;
    step(S);
    check("busy_early", int'(busy), 0);
    step(1);
    check("busy_rise", int'(busy), 1);
    fb_in = 1'b1;
    e.cyc = c + 1 + (S + 1) + S; e.mag = S + 1; e.sign = 0;
    sb.push_back(e);
    step(3);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(S + 3);
    check("busy_after_pair", int'(busy), 0);

    // basic pairs
    pair(1'b1, 7);
    pair(1'b0, 3);
    pair(1'b1, 1);
    pair(1'b0, 12);

    // coincident edges: zero error, window never opens
    ref_in = 1'b1;
    fb_in  = 1'b1;
    e.cyc = cyc + 1 + S; e.mag = 0; e.sign = 0;
    sb.push_back(e);
    for (int i = 0; i < S + 4; i++) begin
      step(1);
      check("coincident_busy", int'(busy), 0);
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(S + 3);

    // saturation, both directions
    pair(1'b1, 40);
    pair(1'b0, 35);
    pair(1'b1, MAXC);

    // cycle slip: two ref edges 12 cycles apart, then fb
    c = cyc;
    ref_in = 1'b1;
    step(3);
    ref_in = 1'b0;
    step(9);
    ref_in = 1'b1;
    e.cyc = c + 1 + 12 + S; e.mag = MAXC; e.sign = 0;
    sb.push_back(e);
    c = cyc;
    step(S + 2);
    check("slip_busy", int'(busy), 1);
    ref_in = 1'b0;
    step(3);
    fb_in = 1'b1;
    e.cyc = (c + 1) + (S + 5) + S; e.mag = S + 5; e.sign = 0;
    sb.push_back(e);
    step(3);
    fb_in = 1'b0;
    step(S + 3);
    check("slip_busy_end", int'(busy), 0);

    // enable drop inside a window
    ref_in = 1'b1;
    step(S + 5);
    check("en_busy_before", int'(busy), 1);
    enable = 1'b0;
    step(1);
    check("en_busy_drop", int'(busy), 0);
    ref_in = 1'b0;
    step(3);
    fb_in = 1'b1;
    step(4);
    fb_in = 1'b0;
    step(4);
    enable = 1'b1;
    step(3);
    check("en_no_spurious", int'(busy), 0);
    pair(1'b1, 5);

    // reset inside a window
    fb_in = 1'b1;
    step(S + 6);
    check("rst_mid_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(error_valid), 0);
    step(2);
    fb_in = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(4);
    check("rst_recover_busy", int'(busy), 0);
    pair(1'b0, 4);
    pair(1'b1, 9);

    step(5);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
